// File: rtl/clock_enable_pkg.sv
// Shared types and constants for the multi-channel clock-enable generator.
package clock_enable_pkg;

  typedef enum logic [1:0] {IDLE, PHASE, RUN} ch_state_e;

  localparam int unsigned CFG_DIV_W   = 8;
  localparam int unsigned CFG_BURST_W = 8;
  localparam int unsigned DIV_ONE     = 1;

  typedef struct packed {
    logic [CFG_DIV_W-1:0]   div;
    logic [CFG_DIV_W-1:0]   phase;
    logic [CFG_BURST_W-1:0] burst;
  } ch_cfg_t;

endpackage

// File: rtl/clock_enable_channel.sv
// One tick channel: IDLE -> PHASE -> RUN FSM with phase, divide and burst counters.
module clock_enable_channel
  import clock_enable_pkg::*;
#(
  parameter int unsigned DIV_W   = CFG_DIV_W,
  parameter int unsigned BURST_W = CFG_BURST_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [DIV_W-1:0]   i_div,
  input  logic [DIV_W-1:0]   i_phase,
  input  logic [BURST_W-1:0] i_burst,
  output logic               o_tick,
  output logic               o_busy,
  output logic               o_done
);

  ch_state_e          r_state;
  logic [DIV_W-1:0]   r_ph_cnt;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [DIV_W-1:0]   r_div_m1;
  logic [BURST_W-1:0] r_burst;
  logic [BURST_W-1:0] r_tick_cnt;
  logic               r_tick;
  logic               r_done;
  logic               r_last;

  logic               w_start;
  logic               w_issue;
  logic               w_final;
  logic [DIV_W-1:0]   w_div_m1;
  logic [BURST_W-1:0] w_cnt_base;
  logic [BURST_W-1:0] w_burst;

  // On the start edge the working copy is not loaded yet, so use the live config.
  always_comb begin
    w_div_m1   = (i_div == '0) ? '0 : i_div - 1'b1;
    w_start    = (r_state == IDLE) && i_start;
    w_cnt_base = w_start ? '0 : r_tick_cnt;
    w_burst    = w_start ? i_burst : r_burst;
    w_issue    = (w_start && (i_phase == '0)) ||
                 ((r_state == PHASE) && (r_ph_cnt == '0)) ||
                 ((r_state == RUN) && !r_last && (r_div_cnt == r_div_m1));
    w_final    = (w_burst != '0) && (w_cnt_base == w_burst - 1'b1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_ph_cnt   <= '0;
      r_div_cnt  <= '0;
      r_div_m1   <= '0;
      r_burst    <= '0;
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      if (i_stop) begin
        r_state <= IDLE;
        r_last  <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (i_start) begin
              r_div_m1   <= w_div_m1;
              r_burst    <= i_burst;
              r_ph_cnt   <= i_phase - 1'b1;
              r_tick_cnt <= '0;
              r_state    <= (i_phase == '0) ? RUN : PHASE;
            end
          end
          PHASE: begin
            if (r_ph_cnt == '0) r_state <= RUN;
            else                r_ph_cnt <= r_ph_cnt - 1'b1;
          end
          RUN: begin
            // The done cycle keeps busy high; leave on the following edge.
            if (r_last) begin
              r_state <= IDLE;
              r_last  <= 1'b0;
            end else if (!w_issue) begin
              r_div_cnt <= r_div_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase

        if (w_issue) begin
          r_tick     <= 1'b1;
          r_done     <= w_final;
          r_last     <= w_final;
          r_tick_cnt <= w_cnt_base + 1'b1;
          r_div_cnt  <= '0;
        end
      end
    end
  end

  assign o_tick = r_tick;
  assign o_done = r_done;
  assign o_busy = (r_state != IDLE);

endmodule

// File: rtl/clock_enable_generator.sv
// Multi-channel tick-enable generator: per-channel shadow config, channel array, cycle counter.
module clock_enable_generator
  import clock_enable_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DIV_W   = CFG_DIV_W,
  parameter int unsigned BURST_W = CFG_BURST_W,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic                                         i_cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] i_cfg_ch,
  input  logic [DIV_W-1:0]                             i_cfg_div,
  input  logic [DIV_W-1:0]                             i_cfg_phase,
  input  logic [BURST_W-1:0]                           i_cfg_burst,
  input  logic [NUM_CH-1:0]                            i_start,
  input  logic [NUM_CH-1:0]                            i_stop,
  output logic [NUM_CH-1:0]                            o_tick,
  output logic [NUM_CH-1:0]                            o_busy,
  output logic [NUM_CH-1:0]                            o_done,
  output logic [CNT_W-1:0]                             o_cycle_count
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CNT_W-1:0] r_cycle_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_cycle_count <= '0;
    else       r_cycle_count <= r_cycle_count + 1'b1;
  end

  assign o_cycle_count = r_cycle_count;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0]   r_sh_div;
    logic [DIV_W-1:0]   r_sh_phase;
    logic [BURST_W-1:0] r_sh_burst;
    logic               w_sel;
    logic [DIV_W-1:0]   w_div;
    logic [DIV_W-1:0]   w_phase;
    logic [BURST_W-1:0] w_burst;

    assign w_sel = i_cfg_we && (i_cfg_ch == CH_W'(g));

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_sh_div   <= DIV_W'(DIV_ONE);
        r_sh_phase <= '0;
        r_sh_burst <= '0;
      end else if (w_sel) begin
        r_sh_div   <= i_cfg_div;
        r_sh_phase <= i_cfg_phase;
        r_sh_burst <= i_cfg_burst;
      end
    end

    // A write landing with a start on the same channel is forwarded to the start.
    assign w_div   = w_sel ? i_cfg_div   : r_sh_div;
    assign w_phase = w_sel ? i_cfg_phase : r_sh_phase;
    assign w_burst = w_sel ? i_cfg_burst : r_sh_burst;

    clock_enable_channel #(
      .DIV_W   (DIV_W),
      .BURST_W (BURST_W)
    ) u_channel (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (i_start[g]),
      .i_stop  (i_stop[g]),
      .i_div   (w_div),
      .i_phase (w_phase),
      .i_burst (w_burst),
      .o_tick  (o_tick[g]),
      .o_busy  (o_busy[g]),
      .o_done  (o_done[g])
    );
  end

endmodule
